// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART register responder.
// Opcodes and response codes are fixed 8-bit values on the wire.
package uart_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_BUSY_HI,
    ST_WAIT_BUSY_LO
  } resp_state_t;

endpackage

// File: rtl/uart_reg_responder.sv
// Decodes read/write command frames arriving from the UART receiver, updates a
// small register file and answers each frame with one byte through the UART transmitter.
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_valid,
  output logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_send,
  input  logic                          tx_busy,
  output logic [NUM_REGS*DATA_BITS-1:0] regs_out,
  output logic                          cmd_done,
  output logic [7:0]                    err_count
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [DATA_BITS:0] NUM_REGS_W = (DATA_BITS + 1)'(NUM_REGS);

  resp_state_t state_q, state_d;
  logic                               isWrite_q, isWrite_d;
  logic                               nak_q, nak_d;
  logic [AW-1:0]                      addr_q, addr_d;
  logic [NUM_REGS-1:0][DATA_BITS-1:0] regs_q, regs_d;
  logic [DATA_BITS-1:0]               txData_q, txData_d;
  logic                               txSend_q, txSend_d;
  logic                               cmdDone_q, cmdDone_d;
  logic [7:0]                         err_q, err_d;
  logic [TW-1:0]                      tmo_q, tmo_d;
  logic                               errInc;

  assign tx_data   = txData_q;
  assign tx_send   = txSend_q;
  assign cmd_done  = cmdDone_q;
  assign err_count = err_q;
  assign regs_out  = regs_q;

  // Frame decode, register update and timeout; every error source funnels into
  // one increment flag so coincident errors are counted once.
  always_comb begin
    state_d   = state_q;
    isWrite_d = isWrite_q;
    nak_d     = nak_q;
    addr_d    = addr_q;
    regs_d    = regs_q;
    txData_d  = txData_q;
    tmo_d     = '0;
    errInc    = 1'b0;
    txSend_d  = (state_q == ST_EXEC);
    cmdDone_d = (state_q == ST_EXEC);

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == DATA_BITS'(CMD_WRITE) || rx_data == DATA_BITS'(CMD_READ)) begin
            isWrite_d = (rx_data == DATA_BITS'(CMD_WRITE));
            nak_d     = 1'b0;
            state_d   = ST_GET_ADDR;
          end else begin
            nak_d   = 1'b1;
            state_d = ST_EXEC;
          end
        end
      end
      ST_GET_ADDR, ST_GET_DATA: begin
        if (rx_valid) begin
          if (state_q == ST_GET_ADDR) begin
            addr_d  = rx_data[AW-1:0];
            nak_d   = ({1'b0, rx_data} >= NUM_REGS_W);
            state_d = isWrite_q ? ST_GET_DATA : ST_EXEC;
          end else begin
            if (!nak_q) regs_d[addr_q] = rx_data;
            state_d = ST_EXEC;
          end
        end else if (tmo_q == TMO_MAX) begin
          errInc  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_EXEC: begin
        if (nak_q)          txData_d = DATA_BITS'(RSP_NAK);
        else if (isWrite_q) txData_d = DATA_BITS'(RSP_ACK);
        else                txData_d = regs_q[addr_q];
        errInc  = nak_q;
        state_d = ST_SEND;
      end
      ST_SEND:         state_d = ST_WAIT_BUSY_HI;
      ST_WAIT_BUSY_HI: if (tx_busy)  state_d = ST_WAIT_BUSY_LO;
      ST_WAIT_BUSY_LO: if (!tx_busy) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase

    if (rx_valid && (state_q inside {ST_EXEC, ST_SEND, ST_WAIT_BUSY_HI, ST_WAIT_BUSY_LO}))
      errInc = 1'b1;

    err_d = (errInc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      isWrite_q <= 1'b0;
      nak_q     <= 1'b0;
      addr_q    <= '0;
      regs_q    <= '0;
      txData_q  <= '0;
      txSend_q  <= 1'b0;
      cmdDone_q <= 1'b0;
      err_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      isWrite_q <= isWrite_d;
      nak_q     <= nak_d;
      addr_q    <= addr_d;
      regs_q    <= regs_d;
      txData_q  <= txData_d;
      txSend_q  <= txSend_d;
      cmdDone_q <= cmdDone_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder; the UART transmitter is modelled by a
// busy window that opens on each tx_send pulse.
module tb_uart_reg_responder;

  localparam int DATA_BITS = 8;
  localparam int NUM_REGS  = 16;
  localparam int TIMEOUT   = 1000;

  logic                          clock = 1'b0;
  logic                          reset = 1'b1;
  logic [DATA_BITS-1:0]          rx_data = '0;
  logic                          rx_valid = 1'b0;
  logic [DATA_BITS-1:0]          tx_data;
  logic                          tx_send;
  logic                          tx_busy;
  logic [NUM_REGS*DATA_BITS-1:0] regs_out;
  logic                          cmd_done;
  logic [7:0]                    err_count;

  int checks = 0;
  int errors = 0;
  int sendCount = 0;
  int cmdDoneCount = 0;
  int busyCnt = 0;
  logic [7:0] lastTx = '0;

  uart_reg_responder #(
    .DATA_BITS(DATA_BITS), .NUM_REGS(NUM_REGS), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .regs_out(regs_out), .cmd_done(cmd_done), .err_count(err_count)
  );

  always #5 clock = ~clock;

  assign tx_busy = (busyCnt != 0);

  // Transmitter stand-in: capture the byte on each send and stay busy for a while.
  always @(negedge clock) begin
    if (reset) begin
      busyCnt = 0;
    end else if (tx_send) begin
      lastTx = tx_data;
      sendCount++;
      busyCnt = 20;
    end else if (busyCnt > 0) begin
      busyCnt--;
    end
    if (cmd_done) cmdDoneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clock); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic waitIdle(input int startCount);
    int n = 0;
    while (sendCount == startCount && n < 200) begin step(1); n++; end
    n = 0;
    while (busyCnt != 0 && n < 200) begin step(1); n++; end
    step(2);
  endtask

  task automatic awaitResponse(input string tag, input logic [7:0] expByte, input int startCount);
    waitIdle(startCount);
    checkOutput({tag, " count"}, 32'(sendCount - startCount), 32'd1);
    checkOutput({tag, " byte"}, {24'd0, lastTx}, {24'd0, expByte});
  endtask

  function automatic logic [7:0] regAt(input int i);
    return regs_out[i*DATA_BITS +: DATA_BITS];
  endfunction

  initial begin
    int sc;
    int cd;
    logic [NUM_REGS*DATA_BITS-1:0] snap;

    step(3);
    reset = 1'b0;
    checkOutput("reset tx_send", {31'd0, tx_send}, 32'd0);
    checkOutput("reset tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset cmd_done", {31'd0, cmd_done}, 32'd0);
    checkOutput("reset err", {24'd0, err_count}, 32'd0);
    checkOutput("reset regs zero", {31'd0, |regs_out}, 32'd0);

    // Write reg3 = A5 with exact cycle timing
    sc = sendCount;
    applyStimulus(8'h57);
    applyStimulus(8'h03);
    applyStimulus(8'hA5);
    checkOutput("wr reg3 at N+1", {24'd0, regAt(3)}, 32'hA5);
    checkOutput("wr no send at N+1", {31'd0, tx_send}, 32'd0);
    step(1);
    checkOutput("wr send at N+2", {31'd0, tx_send}, 32'd1);
    checkOutput("wr done at N+2", {31'd0, cmd_done}, 32'd1);
    checkOutput("wr tx_data N+2", {24'd0, tx_data}, 32'h06);
    step(1);
    checkOutput("wr send drops N+3", {31'd0, tx_send}, 32'd0);
    checkOutput("wr tx_data held", {24'd0, tx_data}, 32'h06);
    awaitResponse("wr ack", 8'h06, sc);
    checkOutput("wr err", {24'd0, err_count}, 32'd0);

    // Read reg3 back
    sc = sendCount;
    cd = cmdDoneCount;
    applyStimulus(8'h52);
    applyStimulus(8'h03);
    awaitResponse("rd reg3", 8'hA5, sc);
    checkOutput("rd cmd_done once", 32'(cmdDoneCount - cd), 32'd1);

    // Out-of-range read and write
    sc = sendCount;
    applyStimulus(8'h52);
    applyStimulus(8'h10);
    awaitResponse("rd oob", 8'h15, sc);
    checkOutput("rd oob err", {24'd0, err_count}, 32'd1);
    snap = regs_out;
    sc = sendCount;
    applyStimulus(8'h57);
    applyStimulus(8'h20);
    applyStimulus(8'hFF);
    awaitResponse("wr oob", 8'h15, sc);
    checkOutput("wr oob regs same", {31'd0, regs_out == snap}, 32'd1);
    checkOutput("wr oob err", {24'd0, err_count}, 32'd2);

    // Unknown opcode
    sc = sendCount;
    applyStimulus(8'h00);
    awaitResponse("bad op", 8'h15, sc);
    checkOutput("bad op err", {24'd0, err_count}, 32'd3);

    // Inter-byte timeout
    sc = sendCount;
    applyStimulus(8'h57);
    step(2000);
    checkOutput("tmo no send", 32'(sendCount - sc), 32'd0);
    checkOutput("tmo err", {24'd0, err_count}, 32'd4);
    sc = sendCount;
    applyStimulus(8'h52);
    applyStimulus(8'h00);
    awaitResponse("tmo next rd", 8'h00, sc);

    // Byte arriving while the response is in flight is dropped
    sc = sendCount;
    applyStimulus(8'h52);
    applyStimulus(8'h03);
    step(6);
    applyStimulus(8'h57);
    awaitResponse("drop rd", 8'hA5, sc);
    checkOutput("drop err", {24'd0, err_count}, 32'd5);
    sc = sendCount;
    applyStimulus(8'h52);
    applyStimulus(8'h03);
    awaitResponse("after drop rd", 8'hA5, sc);

    // Reset in GET_DATA
    sc = sendCount;
    applyStimulus(8'h57);
    applyStimulus(8'h05);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("rst1 regs zero", {31'd0, |regs_out}, 32'd0);
    checkOutput("rst1 err", {24'd0, err_count}, 32'd0);
    checkOutput("rst1 tx_send", {31'd0, tx_send}, 32'd0);
    step(30);
    checkOutput("rst1 no send", 32'(sendCount - sc), 32'd0);
    sc = sendCount;
    applyStimulus(8'h57);
    applyStimulus(8'h05);
    applyStimulus(8'h3C);
    awaitResponse("rst1 wr", 8'h06, sc);
    sc = sendCount;
    applyStimulus(8'h52);
    applyStimulus(8'h05);
    awaitResponse("rst1 rd", 8'h3C, sc);

    // Reset in WAIT_BUSY_LO
    sc = sendCount;
    applyStimulus(8'h57);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    step(8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("rst2 tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst2 regs zero", {31'd0, |regs_out}, 32'd0);
    step(30);
    checkOutput("rst2 one send", 32'(sendCount - sc), 32'd1);
    sc = sendCount;
    applyStimulus(8'h57);
    applyStimulus(8'h07);
    applyStimulus(8'hC3);
    awaitResponse("rst2 wr", 8'h06, sc);
    sc = sendCount;
    applyStimulus(8'h52);
    applyStimulus(8'h07);
    awaitResponse("rst2 rd", 8'hC3, sc);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      sc = sendCount;
      applyStimulus(8'hEE);
      waitIdle(sc);
    end
    checkOutput("err saturate", {24'd0, err_count}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
